// File: rtl/alu_step_unit_if.sv
// Button/switch/LED bundle between the panel side (master) and the ALU step unit (slave).
interface alu_step_unit_if #(
    parameter int WIDTH = 4
);
    logic             tick;
    logic [3:0]       pb;
    logic [WIDTH-1:0] sw;
    logic [2:0]       op;
    logic             show_flags;
    logic [WIDTH-1:0] led;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output tick, pb, sw, op, show_flags,
        input  led, res_q, flags, busy, done
    );

    modport slave (
        input  tick, pb, sw, op, show_flags,
        output led, res_q, flags, busy, done
    );
endinterface

// File: rtl/alu_step_unit.sv
// Pushbutton-driven ALU: synchronised/debounced buttons load operands and launch
// single-cycle ops or a WIDTH-cycle shift-add multiply; result and C/V/Z/N are held.
//
// state | meaning
// IDLE  | waiting for button events; loads and clear handled here
// EXEC  | single-cycle arithmetic/logic op, result registered on exit
// MUL   | shift-add multiply, one partial product per clk
module alu_step_unit #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_step_unit_if.slave bus
);
    localparam int MSB  = WIDTH - 1;
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int CNTW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    logic [3:0]     sync_q [SYNC_STAGES];
    logic [3:0]     stable_q;
    logic [3:0]     stable_d;
    logic [DBW-1:0] db_cnt [4];
    logic [3:0]     synced;
    logic [3:0]     ev;

    assign synced = sync_q[SYNC_STAGES-1];
    assign ev     = stable_q & ~stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
            stable_q <= '0;
            stable_d <= '0;
        end else begin
            sync_q[0] <= bus.pb;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            stable_d <= stable_q;
            if (bus.tick) begin
                for (int i = 0; i < 4; i++) begin
                    // any tick agreeing with the stable level restarts the run
                    if (synced[i] != stable_q[i]) begin
                        if (db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
                            stable_q[i] <= ~stable_q[i];
                            db_cnt[i]   <= '0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + DBW'(1);
                        end
                    end else begin
                        db_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    logic [1:0]         state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic [CNTW-1:0]    mul_cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flag_q;
    logic               done_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_hi_nz;

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            3'b001: begin
                sum     = {1'b0, a_q} - {1'b0, b_q};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = ~a_q;
            3'b110: begin
                alu_res = {a_q[MSB-1:0], 1'b0};
                alu_c   = a_q[MSB];
                alu_v   = a_q[MSB] ^ a_q[MSB-1];
            end
            default: alu_res = '0;
        endcase
    end

    assign acc_next  = mul_b_q[0] ? acc_q + mul_a_q : acc_q;
    assign mul_hi_nz = |acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_cnt_q <= '0;
            result_q  <= '0;
            flag_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ev[3]) begin
                a_q      <= '0;
                b_q      <= '0;
                result_q <= '0;
                flag_q   <= '0;
                state_q  <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ev[2]) begin
                            op_q <= bus.op;
                            if (bus.op == 3'b111) begin
                                state_q   <= S_MUL;
                                acc_q     <= '0;
                                mul_a_q   <= {{WIDTH{1'b0}}, a_q};
                                mul_b_q   <= b_q;
                                mul_cnt_q <= CNTW'(WIDTH - 1);
                            end else begin
                                state_q <= S_EXEC;
                            end
                        end else begin
                            if (ev[0]) a_q <= bus.sw;
                            if (ev[1]) b_q <= bus.sw;
                        end
                    end
                    S_EXEC: begin
                        result_q <= alu_res;
                        flag_q   <= {alu_c, alu_v, alu_res == '0, alu_res[MSB]};
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                    S_MUL: begin
                        acc_q   <= acc_next;
                        mul_a_q <= mul_a_q << 1;
                        mul_b_q <= mul_b_q >> 1;
                        if (mul_cnt_q == '0) begin
                            result_q <= acc_next[MSB:0];
                            flag_q   <= {mul_hi_nz, mul_hi_nz, acc_next[MSB:0] == '0, acc_next[MSB]};
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            mul_cnt_q <= mul_cnt_q - CNTW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.res_q = result_q;
    assign bus.flags = flag_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q;
    assign bus.led   = bus.show_flags ? WIDTH'(flag_q) : result_q;
endmodule
